// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller: per-stage stall/flush generation for
//   backpressure, load-use and branch redirect, plus a RUN/DRAIN/TRAP/HALT
//   sequencer for trap entry and debug halt, and two saturating counters.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   stage_valid_i[N]     stage holds a live instruction (index 0 = IF)
//   stage_busy_i[N]      stage cannot advance this cycle
//   load_use_hazard_i    ID consumes an EX load result
//   redirect_i           taken branch / jump at REDIRECT_STAGE
//   trap_req_i           exception / interrupt request
//   halt_req_i           debug halt request
//   resume_i             debug resume
//   clr_cnt_i            clear performance counters
//   stall_o[N]           per-stage hold
//   flush_o[N]           per-stage bubble insert
//   trap_ack_o           one-cycle trap-entry pulse
//   halted_o             core halted
//   state_o              RUN=0, DRAIN=1, TRAP=2, HALT=3
//   stall_cycles_o       RUN cycles with stall_o[0]=1 (saturating)
//   redirect_cnt_o       accepted redirects (saturating)
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int REDIRECT_STAGE = 2,
    parameter int DRAIN_TIMEOUT  = 16,
    parameter int CNT_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_STAGES-1:0] stage_valid_i,
    input  logic [NUM_STAGES-1:0] stage_busy_i,
    input  logic                  load_use_hazard_i,
    input  logic                  redirect_i,
    input  logic                  trap_req_i,
    input  logic                  halt_req_i,
    input  logic                  resume_i,
    input  logic                  clr_cnt_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  trap_ack_o,
    output logic                  halted_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DCNT_W-1:0]     DCNT_LAST  = DCNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] REDIR_MASK = NUM_STAGES'((1 << REDIRECT_STAGE) - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_trap_pend, r_halt_pend;
    logic [DCNT_W-1:0]     r_dcnt;
    logic [CNT_W-1:0]      r_stall_cnt, r_redir_cnt;

    logic [NUM_STAGES-1:0] w_busy_eff, w_bstall, w_bflush;
    logic [NUM_STAGES-1:0] w_stall, w_flush;
    logic                  w_redir_acc, w_trap_ack, w_halted;
    logic                  w_drained, w_tmo;
    logic                  w_unused;

    // Stage 0 is force-held during DRAIN, so its busy bit must not create a
    // bubble in stage 1.
    assign w_busy_eff = (r_state == ST_DRAIN) ? {stage_busy_i[NUM_STAGES-1:1], 1'b0}
                                              : stage_busy_i;

    // Backpressure: stage k holds if any stage at or beyond k is busy; the
    // stage just past the highest busy one gets a bubble.
    assign w_bflush[0] = 1'b0;
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_bstall
        assign w_bstall[k] = |w_busy_eff[NUM_STAGES-1:k];
        if (k > 0) begin : g_bflush
            assign w_bflush[k] = w_bstall[k-1] & ~w_bstall[k];
        end
    end

    assign w_drained = ~|stage_valid_i[NUM_STAGES-1:1];
    assign w_tmo     = (r_dcnt == DCNT_LAST);
    assign w_unused  = stage_valid_i[0];

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = '0;
        w_flush     = '0;
        w_redir_acc = 1'b0;
        w_trap_ack  = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall     = w_bstall;
                w_flush     = w_bflush;
                w_redir_acc = redirect_i & ~w_bstall[REDIRECT_STAGE];
                // An accepted redirect kills the load consumer, so load-use
                // is only applied when no redirect is taken.
                if (load_use_hazard_i && !w_redir_acc) begin
                    w_stall[1:0] = 2'b11;
                    if (!w_bstall[2]) begin
                        w_flush[2] = 1'b1;
                    end
                end
                if (w_redir_acc) begin
                    w_stall = w_stall & ~REDIR_MASK;
                    w_flush = w_flush | REDIR_MASK;
                end
                if (trap_req_i || halt_req_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_stall    = w_bstall;
                w_stall[0] = 1'b1;
                w_flush    = w_bflush;
                w_flush[0] = 1'b1;
                if (w_drained || w_tmo) begin
                    w_state_nxt = r_trap_pend ? ST_TRAP : ST_HALT;
                    if (!w_drained) begin
                        w_flush = '1;
                    end
                end
            end
            ST_TRAP: begin
                w_flush     = '1;
                w_trap_ack  = 1'b1;
                w_state_nxt = r_halt_pend ? ST_DRAIN : ST_RUN;
            end
            ST_HALT: begin
                w_stall  = '1;
                w_halted = 1'b1;
                if (resume_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (!rst_ni) begin
            w_stall     = '1;
            w_flush     = '1;
            w_trap_ack  = 1'b0;
            w_halted    = 1'b0;
            w_redir_acc = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_RUN;
            r_trap_pend <= 1'b0;
            r_halt_pend <= 1'b0;
            r_dcnt      <= '0;
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN && (trap_req_i || halt_req_i)) begin
                r_trap_pend <= trap_req_i;
                r_halt_pend <= halt_req_i;
            end
            if (r_state == ST_TRAP) begin
                r_trap_pend <= 1'b0;
            end
            if (r_state == ST_HALT && resume_i) begin
                r_halt_pend <= 1'b0;
            end
            if (r_state == ST_DRAIN && w_state_nxt == ST_DRAIN) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else begin
                r_dcnt <= '0;
            end
            if (clr_cnt_i) begin
                r_stall_cnt <= '0;
                r_redir_cnt <= '0;
            end else begin
                if (r_state == ST_RUN && w_stall[0] && !(&r_stall_cnt)) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                if (w_redir_acc && !(&r_redir_cnt)) begin
                    r_redir_cnt <= r_redir_cnt + 1'b1;
                end
            end
        end
    end

    assign stall_o        = w_stall;
    assign flush_o        = w_flush;
    assign trap_ack_o     = w_trap_ack;
    assign halted_o       = w_halted;
    assign state_o        = r_state;
    assign stall_cycles_o = r_stall_cnt;
    assign redirect_cnt_o = r_redir_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int NS   = 5;
    localparam int RS   = 2;
    localparam int TMO  = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NS-1:0] valid, busy;
    logic          lu, redir, trap, halt, resume, clr;
    logic [NS-1:0] stall, flush;
    logic          ack, halted;
    logic [1:0]    state;
    logic [CW-1:0] sc, rc;

    pipe_hazard_ctrl #(
        .NUM_STAGES    (NS),
        .REDIRECT_STAGE(RS),
        .DRAIN_TIMEOUT (TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .stage_valid_i    (valid),
        .stage_busy_i     (busy),
        .load_use_hazard_i(lu),
        .redirect_i       (redir),
        .trap_req_i       (trap),
        .halt_req_i       (halt),
        .resume_i         (resume),
        .clr_cnt_i        (clr),
        .stall_o          (stall),
        .flush_o          (flush),
        .trap_ack_o       (ack),
        .halted_o         (halted),
        .state_o          (state),
        .stall_cycles_o   (sc),
        .redirect_cnt_o   (rc)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0=RUN 1=DRAIN 2=TRAP 3=HALT
    int m_mode, m_dcnt, m_sc, m_rc;
    bit m_tp, m_hp;

    // Expected outputs for the current cycle
    logic [NS-1:0] e_stall, e_flush;
    bit            e_ack, e_halted, e_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compute expected outputs from the model and compare, away from the edge.
    task automatic sample();
        int hb;
        @(negedge clk);
        hb       = -1;
        e_stall  = '0;
        e_flush  = '0;
        e_ack    = 0;
        e_halted = 0;
        e_acc    = 0;
        if (!rst_n) begin
            e_stall = '1;
            e_flush = '1;
        end else begin
            case (m_mode)
                0: begin
                    for (int j = 0; j < NS; j++) if (busy[j]) hb = j;
                    for (int k = 0; k < NS; k++) e_stall[k] = (k <= hb);
                    if (hb >= 0 && hb + 1 < NS) e_flush[hb+1] = 1'b1;
                    e_acc = redir && (hb < RS);
                    if (lu && !e_acc) begin
                        e_stall[0] = 1'b1;
                        e_stall[1] = 1'b1;
                        if (hb < 2) e_flush[2] = 1'b1;
                    end
                    if (e_acc) begin
                        for (int k = 0; k < RS; k++) begin
                            e_stall[k] = 1'b0;
                            e_flush[k] = 1'b1;
                        end
                    end
                end
                1: begin
                    for (int j = 1; j < NS; j++) if (busy[j]) hb = j;
                    for (int k = 1; k < NS; k++) e_stall[k] = (k <= hb);
                    e_stall[0] = 1'b1;
                    e_flush[0] = 1'b1;
                    if (hb >= 1 && hb + 1 < NS) e_flush[hb+1] = 1'b1;
                    if (m_dcnt == TMO - 1 && valid[NS-1:1] != 0) e_flush = '1;
                end
                2: begin
                    e_flush = '1;
                    e_ack   = 1;
                end
                default: begin
                    e_stall  = '1;
                    e_halted = 1;
                end
            endcase
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("trap_ack", 32'(ack), 32'(e_ack));
        chk("halted", 32'(halted), 32'(e_halted));
        chk("state", 32'(state), 32'(m_mode));
        chk("stall_cycles", 32'(sc), 32'(m_sc));
        chk("redirect_cnt", 32'(rc), 32'(m_rc));
    endtask

    // Advance the model by one clock edge, then wait for that edge.
    task automatic advance();
        if (!rst_n) begin
            m_mode = 0; m_tp = 0; m_hp = 0; m_dcnt = 0; m_sc = 0; m_rc = 0;
        end else begin
            if (clr) begin
                m_sc = 0;
                m_rc = 0;
            end else begin
                if (m_mode == 0 && e_stall[0] && m_sc < CMAX) m_sc++;
                if (e_acc && m_rc < CMAX) m_rc++;
            end
            case (m_mode)
                0: if (trap || halt) begin
                    m_mode = 1; m_tp = trap; m_hp = halt; m_dcnt = 0;
                end
                1: if (valid[NS-1:1] == 0 || m_dcnt == TMO - 1) begin
                    m_mode = m_tp ? 2 : 3; m_dcnt = 0;
                end else begin
                    m_dcnt++;
                end
                2: begin
                    m_tp = 0; m_mode = m_hp ? 1 : 0; m_dcnt = 0;
                end
                default: if (resume) begin
                    m_hp = 0; m_mode = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        busy = '0; lu = 0; redir = 0; trap = 0; halt = 0; resume = 0; clr = 0;
    endtask

    initial begin
        logic [CW-1:0] snap;
        rst_n = 0;
        valid = '0;
        idle_inputs();
        @(posedge clk);
        #1;
        m_mode = 0; m_tp = 0; m_hp = 0; m_dcnt = 0; m_sc = 0; m_rc = 0;

        // Reset values
        sample();
        chk("rst_stall", 32'(stall), 32'h1f);
        chk("rst_flush", 32'(flush), 32'h1f);
        chk("rst_state", 32'(state), 0);
        advance();
        rst_n = 1;
        valid = '1;

        // Busy at stage 3
        busy = 5'b01000;
        sample();
        chk("busy_stall", 32'(stall), 32'b01111);
        chk("busy_flush", 32'(flush), 32'b10000);
        snap = sc;
        advance();
        sample();
        chk("busy_stallcnt", 32'(sc), 32'(snap) + 1);
        advance();

        // Load-use plus redirect
        busy = '0; lu = 1; redir = 1;
        sample();
        chk("lu_redir_stall", 32'(stall), 0);
        chk("lu_redir_flush", 32'(flush), 32'b00011);
        snap = rc;
        advance();
        lu = 0; redir = 0;
        sample();
        chk("lu_redir_cnt", 32'(rc), 32'(snap) + 1);
        advance();

        // Load-use alone
        lu = 1;
        sample();
        chk("lu_stall", 32'(stall), 32'b00011);
        chk("lu_flush", 32'(flush), 32'b00100);
        advance();

        // Stalled redirect
        lu = 0; redir = 1; busy = 5'b01000;
        sample();
        chk("stalled_redir_flush", 32'(flush & 5'b00011), 0);
        snap = rc;
        advance();
        redir = 0; busy = '0;
        sample();
        chk("stalled_redir_cnt", 32'(rc), 32'(snap));
        advance();

        // Trap: valid clears 3 cycles after the request
        trap = 1;
        cyc();
        trap = 0;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("trap_drain", 32'(state), 1);
            advance();
        end
        valid = '0;
        sample();
        chk("trap_drain_last", 32'(state), 1);
        advance();
        sample();
        chk("trap_state", 32'(state), 2);
        chk("trap_ack", 32'(ack), 1);
        chk("trap_flush", 32'(flush), 32'h1f);
        advance();
        sample();
        chk("trap_back_run", 32'(state), 0);
        advance();

        // Timeout with trap and halt together
        valid = 5'b00100;
        trap = 1; halt = 1;
        cyc();
        trap = 0; halt = 0;
        for (int i = 0; i < TMO; i++) begin
            sample();
            chk("tmo_drain1", 32'(state), 1);
            if (i == TMO - 1) chk("tmo_forced_flush", 32'(flush), 32'h1f);
            advance();
        end
        sample();
        chk("tmo_trap", 32'(state), 2);
        chk("tmo_ack", 32'(ack), 1);
        advance();
        for (int i = 0; i < TMO; i++) begin
            sample();
            chk("tmo_drain2", 32'(state), 1);
            advance();
        end
        trap = 1; halt = 1;
        sample();
        chk("tmo_halt", 32'(state), 3);
        chk("tmo_halted", 32'(halted), 1);
        advance();
        trap = 0; halt = 0; resume = 1;
        sample();
        chk("halt_ignores_req", 32'(state), 3);
        advance();
        resume = 0;
        sample();
        chk("resume_run", 32'(state), 0);
        advance();

        // Counter saturation and clear priority
        valid = '1;
        lu = 1; redir = 0;
        for (int i = 0; i < CMAX + 4; i++) cyc();
        sample();
        chk("sat_stall_cnt", 32'(sc), CMAX);
        advance();
        lu = 0; redir = 1;
        for (int i = 0; i < CMAX + 4; i++) cyc();
        sample();
        chk("sat_redir_cnt", 32'(rc), CMAX);
        advance();
        clr = 1;
        cyc();
        clr = 0; redir = 0;
        sample();
        chk("clr_stall_cnt", 32'(sc), 0);
        chk("clr_redir_cnt", 32'(rc), 0);
        advance();

        // Reset mid-HALT
        valid = '0; halt = 1;
        cyc();
        halt = 0;
        cyc();
        sample();
        chk("pre_rst_halt", 32'(state), 3);
        advance();
        rst_n = 0;
        sample();
        chk("rst_halted", 32'(halted), 0);
        chk("rst_mid_stall", 32'(stall), 32'h1f);
        advance();
        sample();
        chk("rst_mid_state", 32'(state), 0);
        advance();
        rst_n = 1;

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 149) != 0);
            valid  = ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom);
            busy   = ($urandom_range(0, 1) == 0) ? '0 : NS'($urandom & $urandom);
            lu     = ($urandom_range(0, 2) == 0);
            redir  = ($urandom_range(0, 2) == 0);
            trap   = ($urandom_range(0, 24) == 0);
            halt   = ($urandom_range(0, 29) == 0);
            resume = ($urandom_range(0, 3) == 0);
            clr    = ($urandom_range(0, 49) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5; stage count, index 0 = IF (oldest index = NUM_STAGES-1).
REQ-002 SHALL have parameter REDIRECT_STAGE, default 2; the stage resolving branches (EX).
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 16; maximum drain cycles before a forced flush.
REQ-004 SHALL have parameter CNT_W, default 32; performance-counter width.
REQ-005 SHALL have ports, in order:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- stage_valid_i  in  NUM_STAGES  stage holds a live instruction.
- stage_busy_i  in  NUM_STAGES  stage cannot advance this cycle (muldiv, memory).
- load_use_hazard_i  in  1  ID consumes an EX load result.
- redirect_i  in  1  branch taken / jump at REDIRECT_STAGE.
- trap_req_i  in  1  exception or interrupt request.
- halt_req_i  in  1  debug halt request.
- resume_i  in  1  debug resume.
- clr_cnt_i  in  1  clear performance counters.
- stall_o  out  NUM_STAGES  per-stage hold.
- flush_o  out  NUM_STAGES  per-stage bubble insert.
- trap_ack_o  out  1  one-cycle trap-entry pulse.
- halted_o  out  1  core halted.
- state_o  out  2  FSM state: RUN=0, DRAIN=1, TRAP=2, HALT=3.
- stall_cycles_o  out  CNT_W  count of RUN cycles with stall_o[0]=1.
- redirect_cnt_o  out  CNT_W  count of accepted redirects.

Function
REQ-006 SHALL compute stall_o and flush_o combinationally from inputs and the registered state; latency 0.
REQ-007 In RUN, SHALL assert stall_o[k] when stage_busy_i[j]=1 for any j>=k (backpressure propagates upstream).
REQ-008 When busy stage j is the highest busy index and j+1<NUM_STAGES, SHALL assert flush_o[j+1] so no duplicate retires.
REQ-009 In RUN, load_use_hazard_i=1 SHALL stall stages 0..1 and flush stage 2, unless stalls from REQ-007 already cover stage 2, in which case flush_o[2]=0.
REQ-010 A redirect is accepted only when redirect_i=1 and stall_o[REDIRECT_STAGE]=0.
REQ-011 An accepted redirect SHALL flush stages 0..REDIRECT_STAGE-1.
REQ-012 An accepted redirect SHALL override load-use stall and flush on those stages.
REQ-013 An unaccepted redirect SHALL produce no flush; the source holds redirect_i.
REQ-014 RUN->DRAIN SHALL occur on trap_req_i=1 or halt_req_i=1.
REQ-015 SHALL latch a trap_pending or halt_pending flag on that transition; trap has priority when both are asserted in the same cycle, and the halt flag stays pending.
REQ-016 In DRAIN, SHALL hold stall_o[0]=1 and flush_o[0]=1 and apply REQ-007/008 to stages 1..NUM_STAGES-1.
REQ-017 In DRAIN, SHALL run a drain counter from 0.
REQ-018 DRAIN exits when stage_valid_i[NUM_STAGES-1:1]==0 or the drain counter reaches DRAIN_TIMEOUT-1.
REQ-019 On a timeout exit, SHALL assert flush_o all-ones for that cycle.
REQ-020 DRAIN SHALL exit to TRAP if trap pending, else to HALT.
REQ-021 In TRAP (exactly one cycle), SHALL assert trap_ack_o=1 and flush_o all-ones, clear trap_pending, then go to DRAIN if halt_pending, else RUN.
REQ-022 In HALT, SHALL hold stall_o all-ones, flush_o=0 and halted_o=1.
REQ-023 In HALT, resume_i=1 SHALL return to RUN next cycle and clear halt_pending.
REQ-024 In HALT, SHALL ignore trap_req_i and halt_req_i.
REQ-025 redirect_i and load_use_hazard_i SHALL be ignored outside RUN.
REQ-026 stall_cycles_o SHALL increment when state=RUN and stall_o[0]=1.
REQ-027 redirect_cnt_o SHALL increment on each accepted redirect.
REQ-028 Both counters SHALL saturate at all-ones.
REQ-029 clr_cnt_i SHALL zero both counters next edge and take priority over an increment in the same cycle.

Reset
REQ-030 While rst_ni=0 at a rising edge, state SHALL become RUN, pending flags 0, drain counter 0 and both counters 0.
REQ-031 While rst_ni=0, outputs SHALL be stall_o all-ones, flush_o all-ones, trap_ack_o=0 and halted_o=0.
REQ-032 Reset asserted mid-DRAIN, TRAP or HALT SHALL abandon the operation with no trap_ack_o pulse.

Verification (NUM_STAGES=5, REDIRECT_STAGE=2, DRAIN_TIMEOUT=16)
REQ-033 Busy: stage_busy_i=5'b01000 -> stall_o=5'b01111, flush_o=5'b10000; stall_cycles_o +1 per cycle.
REQ-034 Load-use plus redirect in the same cycle: load_use=1 with redirect_i=1, no busy -> stall_o=0, flush_o=5'b00011, redirect_cnt_o +1.
REQ-035 Stalled redirect: redirect_i=1 with stage_busy_i[3]=1 -> flush_o[1:0]=0, redirect_cnt_o unchanged.
REQ-036 Trap: trap_req_i pulse, stage_valid_i clears 3 cycles later -> DRAIN for 3 cycles, then TRAP with trap_ack_o=1 and flush_o=5'b11111 for 1 cycle, then RUN.
REQ-037 Timeout: trap and halt asserted together, stage_valid_i stuck at 5'b00100 -> 16 DRAIN cycles, forced flush, TRAP, second DRAIN, HALT with halted_o=1; resume_i -> RUN.
REQ-038 Reset/saturation: counter preloaded to all-ones -> stays all-ones; clr_cnt_i -> 0; rst_ni=0 mid-HALT -> state_o=0, halted_o=0 next edge.
